// File: rtl/mult_div_unit_if.sv
// Handshake/data bundle for mult_div_unit.
//   master: drives operands and start pulses, receives result, exception and ready.
//   slave : the arithmetic unit side.
//   data_operandA/B : signed 32-bit operands, sampled only on the start edge
//   ctrl_MULT/DIV   : one-cycle start pulses (MULT wins if both are high)
//   data_result     : product low word or quotient
//   data_exception  : error flag, valid with data_resultRDY
//   data_resultRDY  : one-cycle completion pulse
interface mult_div_unit_if;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  modport master (
    output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    input  data_result, data_exception, data_resultRDY
  );

  modport slave (
    input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    output data_result, data_exception, data_resultRDY
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative signed 32-bit multiply / divide unit.
//   Multiply: radix-2 Booth, one iteration per cycle, 32 iterations.
//   Divide  : restoring division on magnitudes, one quotient bit per cycle, 32 iterations,
//             quotient rounded toward zero.
//   data_resultRDY pulses for one cycle 33 cycles after the start edge. A new start in any
//   state aborts the running operation.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous, active-high
//   bus   : mult_div_unit_if.slave (operands, start pulses, result, exception, ready)
// Configuration:
//   MULT_DIV_UNIT_DIVIDE_EN - when defined the divider datapath is built; otherwise ctrl_DIV
//   completes on the next edge with result 0 and the exception flag set.
module mult_div_unit (
  input  logic           clock,
  input  logic           reset,
  mult_div_unit_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e      state_q;
  logic [5:0]  cnt_q;
  logic [31:0] opa_q;     // latched multiplicand / dividend
  logic [31:0] result_q;
  logic        exc_q;
  logic        rdy_q;

  // Booth state: {acc_q, mq_q, qm1_q}. acc_q carries one guard bit so that subtracting
  // the most negative multiplicand cannot overflow.
  logic [32:0] acc_q;
  logic [31:0] mq_q;
  logic        qm1_q;

  logic [32:0] mcand;
  logic [32:0] acc_sum;
  logic [63:0] product;
  logic        mul_exc;

  assign mcand   = {opa_q[31], opa_q};
  assign product = {acc_q[31:0], mq_q};
  assign mul_exc = product[63:32] != {32{product[31]}};

  always_comb begin
    acc_sum = acc_q;
    case ({mq_q[0], qm1_q})
      2'b01:   acc_sum = acc_q + mcand;
      2'b10:   acc_sum = acc_q - mcand;
      default: acc_sum = acc_q;
    endcase
  end

`ifdef MULT_DIV_UNIT_DIVIDE_EN
  logic [31:0] opb_q;
  logic [31:0] rem_q;
  logic [31:0] quo_q;     // dividend magnitude shifting out, quotient bits shifting in

  logic [31:0] abs_a_in;
  logic [31:0] abs_b;
  logic [32:0] shifted;
  logic [32:0] diff;
  logic [31:0] quotient;
  logic        div_by_zero;
  logic        div_ovf;

  assign abs_a_in    = bus.data_operandA[31] ? -bus.data_operandA : bus.data_operandA;
  assign abs_b       = opb_q[31] ? -opb_q : opb_q;
  assign shifted     = {rem_q, quo_q[31]};
  assign diff        = shifted - {1'b0, abs_b};
  assign quotient    = (opa_q[31] ^ opb_q[31]) ? -quo_q : quo_q;
  assign div_by_zero = opb_q == 32'h0000_0000;
  assign div_ovf     = (opa_q == 32'h8000_0000) && (opb_q == 32'hFFFF_FFFF);
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      opa_q    <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
      acc_q    <= '0;
      mq_q     <= '0;
      qm1_q    <= 1'b0;
`ifdef MULT_DIV_UNIT_DIVIDE_EN
      opb_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
`endif
    end else begin
      rdy_q <= 1'b0;
      if (bus.ctrl_MULT) begin
        opa_q    <= bus.data_operandA;
        acc_q    <= '0;
        mq_q     <= bus.data_operandB;
        qm1_q    <= 1'b0;
        cnt_q    <= '0;
        result_q <= '0;
        exc_q    <= 1'b0;
        state_q  <= StMul;
      end else if (bus.ctrl_DIV) begin
`ifdef MULT_DIV_UNIT_DIVIDE_EN
        opa_q    <= bus.data_operandA;
        opb_q    <= bus.data_operandB;
        rem_q    <= '0;
        quo_q    <= abs_a_in;
        cnt_q    <= '0;
        result_q <= '0;
        exc_q    <= 1'b0;
        state_q  <= StDiv;
`else
        cnt_q    <= '0;
        result_q <= '0;
        exc_q    <= 1'b1;
        rdy_q    <= 1'b1;
        state_q  <= StDone;
`endif
      end else begin
        case (state_q)
          StMul: begin
            // Iterations on counts 0..31; count 32 is the result-publishing edge.
            if (cnt_q == 6'd32) begin
              result_q <= product[31:0];
              exc_q    <= mul_exc;
              rdy_q    <= 1'b1;
              state_q  <= StDone;
            end else begin
              acc_q <= {acc_sum[32], acc_sum[32:1]};
              mq_q  <= {acc_sum[0], mq_q[31:1]};
              qm1_q <= mq_q[0];
              cnt_q <= cnt_q + 6'd1;
            end
          end
          StDiv: begin
`ifdef MULT_DIV_UNIT_DIVIDE_EN
            if (cnt_q == 6'd32) begin
              if (div_by_zero) begin
                result_q <= 32'h0000_0000;
                exc_q    <= 1'b1;
              end else if (div_ovf) begin
                result_q <= 32'h8000_0000;
                exc_q    <= 1'b1;
              end else begin
                result_q <= quotient;
                exc_q    <= 1'b0;
              end
              rdy_q   <= 1'b1;
              state_q <= StDone;
            end else begin
              if (!diff[32]) begin
                rem_q <= diff[31:0];
                quo_q <= {quo_q[30:0], 1'b1};
              end else begin
                rem_q <= shifted[31:0];
                quo_q <= {quo_q[30:0], 1'b0};
              end
              cnt_q <= cnt_q + 6'd1;
            end
`else
            state_q <= StIdle;
`endif
          end
          StDone:  state_q <= StIdle;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = rdy_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes expected results (from a plain
// arithmetic reference model) into a queue; a monitor pops and compares on data_resultRDY.
module tb_mult_div_unit;

`ifdef MULT_DIV_UNIT_DIVIDE_EN
  localparam bit DivEn = 1'b1;
`else
  localparam bit DivEn = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  mult_div_unit_if bus ();

  mult_div_unit dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int unsigned due;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned cyc = 0;
  int          tests = 0;
  int          fails = 0;
  logic [31:0] last_res = '0;
  logic        last_exc = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic exp_t model(bit is_mul, logic [31:0] a, logic [31:0] b);
    exp_t   e;
    longint p;
    e.due = 0;
    if (is_mul) begin
      p     = longint'($signed(a)) * longint'($signed(b));
      e.res = p[31:0];
      e.exc = (p != longint'($signed(e.res)));
    end else if (!DivEn) begin
      e.res = 32'h0;
      e.exc = 1'b1;
    end else if (b == 32'h0) begin
      e.res = 32'h0;
      e.exc = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.res = 32'h8000_0000;
      e.exc = 1'b1;
    end else begin
      e.res = $signed(a) / $signed(b);
      e.exc = 1'b0;
    end
    return e;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      5:       return $urandom_range(0, 40) - 20;
      default: return $urandom;
    endcase
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clock) begin : monitor
    exp_t e;
    if (bus.data_resultRDY === 1'b1) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_rdy: got data_resultRDY=1 at cycle %0d, required 0", cyc);
      end else begin
        e = sb_q.pop_front();
        check("result", bus.data_result, e.res);
        check("exception", 32'(bus.data_exception), 32'(e.exc));
        check("latency", cyc, e.due);
        last_res = e.res;
        last_exc = e.exc;
      end
    end
  end

  task automatic start(bit m, bit d, logic [31:0] a, logic [31:0] b, bit track);
    exp_t        e;
    int unsigned lat;
    @(negedge clock);
    bus.data_operandA = a;
    bus.data_operandB = b;
    bus.ctrl_MULT     = m;
    bus.ctrl_DIV      = d;
    @(posedge clock);
    #1;
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    // Scramble operands after the start edge; the unit must not care.
    bus.data_operandA = $urandom;
    bus.data_operandB = $urandom;
    lat = (m || DivEn) ? 33 : 0;
    if (lat != 0) begin
      check("busy_result", bus.data_result, 32'h0);
      check("busy_exc", 32'(bus.data_exception), 32'h0);
    end
    if (track) begin
      e     = model(m, a, b);
      e.due = cyc + lat;
      sb_q.push_back(e);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (sb_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL timeout: got %0d results outstanding, required 0", sb_q.size());
      sb_q.delete();
    end else begin
      repeat (3) @(negedge clock);
      #1;
      check("hold_result", bus.data_result, last_res);
      check("hold_exc", 32'(bus.data_exception), 32'(last_exc));
    end
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1);
  end

  initial begin : stim
    logic [31:0] a;
    logic [31:0] b;
    bit          op;
    reset             = 1'b1;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_result", bus.data_result, 32'h0);
    check("reset_exc", 32'(bus.data_exception), 32'h0);
    check("reset_rdy", 32'(bus.data_resultRDY), 32'h0);
    @(negedge clock);
    reset = 1'b0;

    // Directed cases.
    start(1'b1, 1'b0, 32'd7, -32'sd3, 1'b1);
    wait_done();
    start(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 1'b1);
    wait_done();
    start(1'b0, 1'b1, -32'sd17, 32'd5, 1'b1);
    wait_done();
    start(1'b0, 1'b1, 32'd9, 32'd0, 1'b1);
    wait_done();
    start(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_done();

    // Restart mid-multiply: only the second operation may complete.
    start(1'b1, 1'b0, 32'd3, 32'd4, 1'b0);
    repeat (8) @(posedge clock);
    start(1'b1, 1'b0, 32'd5, 32'd6, 1'b1);
    wait_done();

    // Simultaneous starts take the multiply path.
    start(1'b1, 1'b1, 32'd6, 32'd2, 1'b1);
    wait_done();

    // Reset mid-operation, with a start pulse on the reset edge that must be ignored.
    start(!DivEn, DivEn, 32'd100, 32'd7, 1'b0);
    repeat (13) @(posedge clock);
    @(negedge clock);
    reset         = 1'b1;
    bus.ctrl_MULT = 1'b1;
    @(posedge clock);
    #1;
    bus.ctrl_MULT = 1'b0;
    check("midreset_result", bus.data_result, 32'h0);
    check("midreset_exc", 32'(bus.data_exception), 32'h0);
    check("midreset_rdy", 32'(bus.data_resultRDY), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    repeat (40) @(negedge clock);
    check("postreset_result", bus.data_result, 32'h0);
    last_res = '0;
    last_exc = 1'b0;

    // Randomized operations.
    for (int i = 0; i < 60; i++) begin
      op = 1'($urandom_range(0, 1));
      a  = pick();
      b  = pick();
      start(op, !op, a, b, 1'b1);
      wait_done();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
